ibex_fetch_queue: RTL

- Parametrised instruction-fetch queue sitting between the IF-stage fetch-address mux and the instruction bus.
- Issues sequential word fetches, tracking up to MaxOutstanding granted-but-unanswered requests.
- Buffers returned words in a Depth-entry FIFO toward the IF-ID register.
- Branches flush the FIFO and squash in-flight responses; a bus error stops prefetching until the next branch.

---
 rtl/ibex_fetch_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ibex_fetch_queue.sv
// Instruction-fetch queue: issues sequential word fetches with a bounded number
// of in-flight bus requests and buffers the returned words toward IF-ID.
module ibex_fetch_queue #(
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic                       branch_i,
  input  logic [31:0]                addr_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [31:0]                rdata_o,
  output logic [31:0]                addr_o,
  output logic                       err_o,
  output logic [$clog2(Depth+1)-1:0] occupancy_o,
  output logic                       instr_req_o,
  output logic [31:0]                instr_addr_o,
  input  logic                       instr_gnt_i,
  input  logic                       instr_rvalid_i,
  input  logic [31:0]                instr_rdata_i,
  input  logic                       instr_err_i,
  output logic                       busy_o
);

  localparam int unsigned OccW = $clog2(Depth + 1);
  localparam int unsigned PtrW = $clog2(Depth);
  // A branch is granted even with MaxOutstanding already in flight, so the
  // request counters need headroom for one more.
  localparam int unsigned CntW = $clog2(MaxOutstanding + 2);

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] tag_cnt_q, tag_cnt_d;
  logic            stop_q, stop_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0] count_q, count_d;
  logic [31:0]     tag_q [MaxOutstanding];
  logic [31:0]     tag_d [MaxOutstanding];
  entry_t          mem_q [Depth];

  logic        branch, room, seq_ok, grant, drop, live_rsp, push, pop;
  logic [31:0] branch_addr;
  entry_t      push_entry, head;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  // Reset also masks the combinational request so every output reads 0 while
  // rst_ni is low, regardless of req_i/branch_i.
  assign branch      = branch_i & rst_ni;
  assign branch_addr = {addr_i[31:2], 2'b00};
  assign room        = (32'(count_q) + 32'(outst_q) - 32'(discard_q)) < Depth;
  assign seq_ok      = req_i & ~stop_q & (32'(outst_q) < MaxOutstanding) & room;

  assign instr_req_o  = rst_ni & (branch_i | seq_ok);
  assign instr_addr_o = branch ? branch_addr : fetch_addr_q;
  assign busy_o       = instr_req_o | (outst_q != '0);

  assign grant    = instr_req_o & instr_gnt_i;
  assign drop     = instr_rvalid_i & (discard_q != '0);
  assign live_rsp = instr_rvalid_i & ~drop;
  assign push     = live_rsp & ~branch;
  assign pop      = valid_o & ready_i & ~branch;

  assign push_entry = '{rdata: instr_rdata_i, addr: tag_q[0], err: instr_err_i};
  assign head       = mem_q[rd_ptr_q];

  assign valid_o     = (count_q != '0);
  assign rdata_o     = valid_o ? head.rdata : '0;
  assign addr_o      = valid_o ? head.addr : '0;
  assign err_o       = valid_o & head.err;
  assign occupancy_o = count_q;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    fetch_addr_d = branch ? branch_addr : fetch_addr_q;
    if (grant) fetch_addr_d = instr_addr_o + 32'd4;

    outst_d   = outst_q + CntW'(grant) - CntW'(instr_rvalid_i);
    discard_d = branch ? (outst_q - CntW'(instr_rvalid_i)) : (discard_q - CntW'(drop));
    stop_d    = branch ? 1'b0 : (stop_q | (push & instr_err_i));

    // The tag FIFO tracks only live requests; stale ones are covered by discard.
    tag_d     = tag_q;
    tag_cnt_d = tag_cnt_q;
    if (branch) begin
      tag_cnt_d = '0;
    end else if (live_rsp) begin
      for (int i = 0; i < int'(MaxOutstanding) - 1; i++) tag_d[i] = tag_q[i+1];
      tag_cnt_d = tag_cnt_q - CntW'(1);
    end
    if (grant) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        if (CntW'(i) == tag_cnt_d) tag_d[i] = instr_addr_o;
      end
      tag_cnt_d = tag_cnt_d + CntW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (branch) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      count_d = count_q + OccW'(push) - OccW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
      tag_cnt_q    <= '0;
      stop_q       <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      tag_cnt_q    <= tag_cnt_d;
      stop_q       <= stop_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: storage arrays are not reset; count_q and tag_cnt_q qualify every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
    tag_q <= tag_d;
  end

  a_rvalid_has_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> (outst_q != '0));
  a_req_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_req_o |-> (instr_addr_o[1:0] == 2'b00));
  a_occupancy_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(count_q) <= Depth);

endmodule
